// File: rtl/serial_mag_cmp_ctrl_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Holds the controller state encoding and the default operand width.
package serial_mag_cmp_ctrl_pkg;

  localparam int CMP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_mag_cmp_ctrl_bit.sv
// One-bit magnitude comparator slice, chained MSB-first through the
// registered cascade: equality so far (e) and greater-than so far (g).
module bit_cmp_slice (
  input  logic a1,
  input  logic b1,
  input  logic e0,
  input  logic g0,
  output logic e1,
  output logic g1
);

  assign e1 = e0 & ~(a1 ^ b1);
  assign g1 = g0 | (e0 & a1 & ~b1);

endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// Bit-serial unsigned magnitude comparator: captures A/B on start, then
// walks one bit per cycle MSB-first, exiting on the first differing bit.
module serial_mag_cmp_ctrl
  import serial_mag_cmp_ctrl_pkg::*;
#(
  parameter int W = CMP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  localparam int CW = $clog2(W);

  state_t          r_state;
  logic [W-1:0]    r_sa;
  logic [W-1:0]    r_sb;
  logic            r_e;
  logic            r_g;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_eq;
  logic            r_gt;
  logic            r_lt;

  logic            w_e1;
  logic            w_g1;
  logic            w_last;

  bit_cmp_slice u_slice (
    .a1 (r_sa[W-1]),
    .b1 (r_sb[W-1]),
    .e0 (r_e),
    .g0 (r_g),
    .e1 (w_e1),
    .g1 (w_g1)
  );

  // Leave RUN after the final bit or as soon as the operands are known to differ.
  assign w_last = (r_cnt == '0) || !w_e1;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain the shift and cascade.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_e     <= 1'b1;
      r_g     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_e     <= 1'b1;
            r_g     <= 1'b0;
            r_cnt   <= CW'(W - 1);
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_e   <= w_e1;
          r_g   <= w_g1;
          r_sa  <= {r_sa[W-2:0], 1'b0};
          r_sb  <= {r_sb[W-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_eq    <= w_e1;
            r_gt    <= w_g1;
            r_lt    <= ~w_e1 & ~w_g1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign eq   = r_eq;
  assign gt   = r_gt;
  assign lt   = r_lt;

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Self-checking bench for serial_mag_cmp_ctrl (W=8): directed corner cases
// plus a randomized back-to-back run against an arithmetic reference model.
module tb_serial_mag_cmp_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         eq;
  logic         gt;
  logic         lt;

  int n_total;
  int n_bad;

  serial_mag_cmp_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference latency: edges after the start-sampling edge until done shows.
  function automatic int ref_latency(input logic [W-1:0] ra, input logic [W-1:0] rb);
    logic [W-1:0] d;
    d = ra ^ rb;
    if (d == '0) return W;
    for (int p = W - 1; p >= 0; p--) begin
      if (d[p]) return W - p;
    end
    return W;
  endfunction

  // Starts from a negedge with the DUT idle; ends at a negedge with it idle.
  task automatic do_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input bit hold, input bit poke, input bit scramble,
                        input string tag);
    int lat;
    int nbusy;
    int exp_lat;
    exp_lat = ref_latency(ta, tb_v);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    if (scramble) begin
      a = W'($urandom);
      b = W'($urandom);
    end
    lat = 0;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      if (poke && lat == 2) begin
        start = 1'b1;
        a = 8'h00;
        b = 8'hFF;
      end else if (poke && lat == 3) begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_run_cycles"}, nbusy, exp_lat);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
    check({tag, "_eq"}, {31'd0, eq}, {31'd0, ta == tb_v});
    check({tag, "_gt"}, {31'd0, gt}, {31'd0, ta > tb_v});
    check({tag, "_lt"}, {31'd0, lt}, {31'd0, ta < tb_v});
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_eq_hold"}, {31'd0, eq}, {31'd0, ta == tb_v});
  endtask

  initial begin
    int extra;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_total = 0;
    n_bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_eq",   {31'd0, eq},   32'd0);
    check("rst_gt",   {31'd0, gt},   32'd0);
    check("rst_lt",   {31'd0, lt},   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_cmp(8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, "equal");
    do_cmp(8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, "msb_exit");
    do_cmp(8'h12, 8'h13, 1'b0, 1'b0, 1'b0, "lsb_lt");
    do_cmp(8'hFF, 8'hFE, 1'b0, 1'b0, 1'b0, "lsb_gt");

    // A start pulsed mid-run must not launch a second comparison.
    do_cmp(8'h40, 8'h40, 1'b0, 1'b1, 1'b0, "busy_start");
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("busy_start_no_second_done", extra, 0);

    // Reset asserted just after edge 3 of a run that would finish at edge 7.
    a = 8'h01;
    b = 8'h02;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_eq",   {31'd0, eq},   32'd0);
    check("midrst_gt",   {31'd0, gt},   32'd0);
    check("midrst_lt",   {31'd0, lt},   32'd0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) extra++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("midrst_no_done", extra, 0);
    do_cmp(8'h03, 8'h03, 1'b0, 1'b0, 1'b0, "after_rst");

    // Back-to-back random comparisons with start held high throughout.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = ra;
      if (i % 8 == 1) rb = ra ^ W'(1 << $urandom_range(W - 1, 0));
      do_cmp(ra, rb, 1'b1, 1'b0, 1'b1, "rand");
    end
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
